// File: rtl/instr_enc_pkg.sv
// Shared types, constants and pure field-packing helpers for the RV32I instruction encoder.
// Immediate range checking (imm_fits) is only consumed when ENC_RANGE_CHECK_EN is defined.
package instr_enc_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } enc_fields_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] word;
  } enc_entry_t;

  function automatic logic fmt_legal(logic [2:0] fmt);
    return fmt <= 3'd5;
  endfunction

  // Place each field at its RV32I bit position; illegal formats become a NOP.
  function automatic logic [XLEN-1:0] pack(enc_fields_t f);
    logic [XLEN-1:0] w;
    w = NOP;
    case (f.fmt)
      FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                  f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = NOP;
    endcase
    return w;
  endfunction

  // True when the immediate survives truncation into its format unchanged.
  function automatic logic imm_fits(enc_fields_t f);
    logic ok;
    ok = 1'b1;
    case (f.fmt)
      FMT_I, FMT_S: ok = (&f.imm[31:11]) || !(|f.imm[31:11]);
      FMT_B:        ok = ((&f.imm[31:12]) || !(|f.imm[31:12])) && !f.imm[0];
      FMT_J:        ok = ((&f.imm[31:20]) || !(|f.imm[31:20])) && !f.imm[0];
      FMT_U:        ok = !(|f.imm[11:0]);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// DEPTH-entry shift-register buffer of {err, word}; head entry is always slot 0.
// wr_ready (not full) and rd_valid (not empty) are registered.
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  enc_entry_t wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output enc_entry_t rd_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  enc_entry_t    mem     [DEPTH];
  enc_entry_t    mem_nxt_c [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;
  logic [CW-1:0] wr_idx_c;
  logic          push_c;
  logic          pop_c;

  assign push_c  = wr_valid && wr_ready;
  assign pop_c   = rd_valid && rd_ready;
  assign rd_data = mem[0];

  // Shift on pop, then write the new entry just behind the surviving ones.
  always_comb begin
    cnt_nxt_c = cnt + CW'(push_c) - CW'(pop_c);
    wr_idx_c  = pop_c ? cnt - CW'(1) : cnt;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_nxt_c[i] = mem[i];
    end
    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_nxt_c[i] = mem[i+1];
      end
    end
    if (push_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_idx_c) mem_nxt_c[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wr_ready <= 1'b1;
      rd_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      cnt      <= cnt_nxt_c;
      wr_ready <= cnt_nxt_c != CW'(DEPTH);
      rd_valid <= cnt_nxt_c != '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= mem_nxt_c[i];
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words and queues them behind a valid/ready buffer.
// Optional macro ENC_RANGE_CHECK_EN: also flag immediates that do not fit their format.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  enc_fields_t fields_c;
  enc_entry_t  entry_c;
  enc_entry_t  head;
  logic        push_c;

  assign fields_c = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, funct3: in_funct3,
                      rs1: in_rs1, rs2: in_rs2, funct7: in_funct7, imm: in_imm};

  always_comb begin
    entry_c.word = pack(fields_c);
    entry_c.err  = !fmt_legal(fields_c.fmt);
`ifdef ENC_RANGE_CHECK_EN
    if (fmt_legal(fields_c.fmt) && !imm_fits(fields_c)) entry_c.err = 1'b1;
`endif
  end

  assign push_c = in_valid && in_ready;

  // Accepted field sets, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
    end else if (push_c) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

  instr_enc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (entry_c),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head)
  );

  assign out_word = head.word;
  assign out_err  = head.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic
// against a queue-based reference model of the encoder and its output buffer.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [2:0]       in_funct3;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err), .enc_count(enc_count)
  );

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic longint unsigned fld(logic [31:0] v, int lo, int w);
    return (64'(v) >> lo) & ((64'd1 << w) - 64'd1);
  endfunction

  // Reference encoding: each field weighted by its bit position, range rules on signed values.
  function automatic exp_t ref_enc(logic [2:0] f, logic [6:0] op, logic [4:0] rd,
                                   logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [6:0] f7, logic [31:0] imm);
    longint unsigned w;
    longint unsigned base;
    int si;
    bit bad;
    bit illegal;
    exp_t r;
    si = $signed(imm);
    bad = 1'b0;
    illegal = 1'b0;
    base = 64'(op);
    case (f)
      3'd0: w = base + 64'(rd) * 128 + 64'(f3) * 4096 + 64'(rs1) * 32768
                + 64'(rs2) * 1048576 + 64'(f7) * 33554432;
      3'd1: begin
        w = base + 64'(rd) * 128 + 64'(f3) * 4096 + 64'(rs1) * 32768 + fld(imm, 0, 12) * 1048576;
        bad = si < -2048 || si > 2047;
      end
      3'd2: begin
        w = base + fld(imm, 0, 5) * 128 + 64'(f3) * 4096 + 64'(rs1) * 32768
            + 64'(rs2) * 1048576 + fld(imm, 5, 7) * 33554432;
        bad = si < -2048 || si > 2047;
      end
      3'd3: begin
        w = base + fld(imm, 11, 1) * 128 + fld(imm, 1, 4) * 256 + 64'(f3) * 4096
            + 64'(rs1) * 32768 + 64'(rs2) * 1048576 + fld(imm, 5, 6) * 33554432
            + fld(imm, 12, 1) * 64'h8000_0000;
        bad = si < -4096 || si > 4095 || fld(imm, 0, 1) != 0;
      end
      3'd4: begin
        w = base + 64'(rd) * 128 + fld(imm, 12, 20) * 4096;
        bad = fld(imm, 0, 12) != 0;
      end
      3'd5: begin
        w = base + 64'(rd) * 128 + fld(imm, 12, 8) * 4096 + fld(imm, 11, 1) * 1048576
            + fld(imm, 1, 10) * 2097152 + fld(imm, 20, 1) * 64'h8000_0000;
        bad = si < -1048576 || si > 1048575 || fld(imm, 0, 1) != 0;
      end
      default: begin
        w = 64'd19;
        illegal = 1'b1;
      end
    endcase
    r.w = 32'(w);
    r.e = illegal || (RANGE_EN && bad);
    return r;
  endfunction

  // Advance one clock and update the model with the handshakes the spec allows.
  task automatic tick();
    bit acc;
    bit pop;
    exp_t e;
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() != 0);
    e = ref_enc(in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (pop) exp_q.delete(0);
      if (acc) begin
        exp_q.push_back(e);
        exp_cnt++;
      end
    end
  endtask

  task automatic drive(int f, int op, int rd, int f3, int rs1, int rs2, int f7, logic [31:0] imm);
    in_fmt = 3'(f); in_opcode = 7'(op); in_rd = 5'(rd); in_funct3 = 3'(f3);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_funct7 = 7'(f7); in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0); in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 32'd0 || out_err !== 1'b0 ||
        enc_count !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: valid=%b word=%h err=%b cnt=%0d rdy=%b, want 0 00000000 0 0 1",
               out_valid, out_word, out_err, enc_count, in_ready);
    end
  endtask

  task automatic test_r_type();
    out_ready = 1'b1;
    drive(0, 'h33, 3, 0, 1, 2, 0, 32'd0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h002081B3 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL r_type: valid=%b word=%h err=%b, want 1 002081b3 0", out_valid, out_word, out_err);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL r_type_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_i_s();
    out_ready = 1'b1;
    drive(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hFFF00093 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL i_type: valid=%b word=%h err=%b, want 1 fff00093 0", out_valid, out_word, out_err);
    end
    drive(2, 'h23, 0, 2, 1, 2, 0, 32'd8);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h0020A423 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL s_type: valid=%b word=%h err=%b, want 1 0020a423 0", out_valid, out_word, out_err);
    end
    tick();
  endtask

  task automatic test_b_j();
    out_ready = 1'b1;
    drive(3, 'h63, 0, 0, 0, 0, 0, -32'sd4);
    tick();
    n_checks++;
    if (out_word !== 32'hFE000EE3 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b_type: word=%h err=%b, want fe000ee3 0", out_word, out_err);
    end
    drive(5, 'h6F, 1, 0, 0, 0, 0, 32'h800);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_word !== 32'h001000EF || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL j_type: word=%h err=%b, want 001000ef 0", out_word, out_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(0, 'h33, 3, 0, 1, 2, 0, 32'd0);
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL bp_first: rdy=%b cnt=%0d, want 1 %0d", in_ready, enc_count, CNT_W'(exp_cnt));
    end
    drive(1, 'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_word !== 32'h002081B3) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b word=%h, want 0 002081b3", in_ready, out_word);
    end
    drive(2, 'h23, 0, 2, 1, 2, 0, 32'd8);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || enc_count !== CNT_W'(exp_cnt) || out_word !== 32'h002081B3) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b cnt=%0d word=%h, want 0 %0d 002081b3",
               in_ready, enc_count, CNT_W'(exp_cnt), out_word);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hFFF00093 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop1: valid=%b word=%h rdy=%b, want 1 fff00093 1", out_valid, out_word, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h0020A423 || enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL bp_third: valid=%b word=%h cnt=%0d, want 1 0020a423 %0d",
               out_valid, out_word, enc_count, CNT_W'(exp_cnt));
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(7, 'h55, 9, 5, 7, 3, 'h7F, 32'h1234_5678);
    tick();
    n_checks++;
    if (out_word !== 32'h00000013 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL fmt7: word=%h err=%b, want 00000013 1", out_word, out_err);
    end
    drive(6, 'h33, 1, 1, 1, 1, 1, 32'd0);
    tick();
    n_checks++;
    if (out_word !== 32'h00000013 || out_err !== 1'b1 || enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL fmt6: word=%h err=%b cnt=%0d, want 00000013 1 %0d",
               out_word, out_err, enc_count, CNT_W'(exp_cnt));
    end
    drive(1, 'h13, 1, 0, 0, 0, 0, 32'd2048);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_word !== 32'h80000093 || out_err !== RANGE_EN) begin
      n_fail++;
      $display("FAIL imm_2048: word=%h err=%b, want 80000093 %b", out_word, out_err, RANGE_EN);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(0, 'h33, 4, 1, 2, 3, 0, 32'd0);
    tick();
    drive(4, 'h37, 5, 0, 0, 0, 0, 32'hABCD_E000);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_rst: valid=%b rdy=%b, want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || enc_count !== '0 || in_ready !== 1'b1 ||
        out_word !== 32'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: valid=%b cnt=%0d rdy=%b word=%h err=%b, want 0 0 1 00000000 0",
               out_valid, enc_count, in_ready, out_word, out_err);
    end
    out_ready = 1'b1;
    drive(0, 'h33, 3, 0, 1, 2, 0, 32'd0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h002081B3 || enc_count !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL post_rst: valid=%b word=%h cnt=%0d, want 1 002081b3 1",
               out_valid, out_word, enc_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] imm;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      drive($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
            $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 127), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++;
      if (in_ready !== (exp_q.size() < DEPTH) || out_valid !== (exp_q.size() != 0) ||
          enc_count !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: rdy=%b valid=%b cnt=%0d, want %b %b %0d", n,
                 in_ready, out_valid, enc_count, exp_q.size() < DEPTH, exp_q.size() != 0,
                 CNT_W'(exp_cnt));
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (out_word !== exp_q[0].w || out_err !== exp_q[0].e) begin
          n_fail++;
          $display("FAIL rnd_data[%0d]: word=%h err=%b, want %h %b", n,
                   out_word, out_err, exp_q[0].w, exp_q[0].e);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_r_type();
    test_i_s();
    test_b_j();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the team's field-extraction instruction decoder: packs opcode, register, funct and immediate fields into a 32-bit RV32I instruction word by format (R/I/S/B/U/J).
- Fields enter on a valid/ready handshake; encoded words leave through a 2-entry output buffer with their own valid/ready.
- Used by the self-test stimulus generator and the boot-ROM loader to build instruction streams in hardware.

Parameters:
- CNT_W, 16, width of the accepted-instruction counter enc_count (wraps modulo 2^CNT_W).
- DEPTH, 2, output buffer entries (legal values: 2 or 4).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- in_fmt  in  3  format code (package enum).
- in_opcode  in  7  opcode, placed at [6:0].
- in_rd  in  5  placed at [11:7] (R/I/U/J).
- in_funct3  in  3  placed at [14:12] (R/I/S/B).
- in_rs1  in  5  placed at [19:15] (R/I/S/B).
- in_rs2  in  5  placed at [24:20] (R/S/B).
- in_funct7  in  7  placed at [31:25] (R only).
- in_imm  in  32  immediate, two's complement, byte-offset form.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts word.
- out_word  out  32  encoded instruction.
- out_err  out  1  error flag travelling with out_word.
- enc_count  out  CNT_W  number of field sets accepted since reset.

Behaviour:
- Reset values: out_valid=0, out_word=0, out_err=0, enc_count=0, buffer empty, in_ready=1 on the first cycle after reset.
- Handshakes: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- in_ready = !full, registered. No push while full, even if a pop occurs in the same cycle.
- Latency: a word accepted at edge N is visible at out_valid/out_word after edge N; one-cycle latency when the buffer is empty.
- Order: strictly FIFO.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- out_valid stays high and out_word/out_err stay stable until popped.
- Packing, fields not listed for a format are zero:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
- Unused immediate bits are dropped silently, except as covered by the optional feature.
- Format codes 6 and 7: word forced to 0x00000013 (NOP), out_err=1, still enqueued and counted.
- enc_count increments on each input transfer and wraps to 0 past all-ones.
- rst asserted mid-operation: buffer flushed, queued words discarded, all outputs return to reset values on the next edge.

Optional Feature:
Macro ENC_RANGE_CHECK_EN.
- Defined: out_err is also set, with the word still encoded and truncated, when the immediate does not fit its format:
  - I/S: not in signed 12-bit range.
  - B: not in signed 13-bit range, or imm[0]≠0.
  - J: not in signed 21-bit range, or imm[0]≠0.
  - U: imm[11:0]≠0.
- Undefined: no range check; out_err only flags illegal formats.

Decomposition:
- Package instr_enc_pkg holds:
  - fmt enum: R=0, I=1, S=2, B=3, U=4, J=5.
  - NOP constant 0x00000013.
  - Opcode constants: OP=0x33, OP_IMM=0x13, STORE=0x23, BRANCH=0x63, LUI=0x37, JAL=0x6F.
  - A pure pack function.
- One sub-module, instr_enc_fifo: DEPTH-entry buffer of {err, word}, providing full/empty and valid/ready.

Test Plan:
- R fmt, op 0x33, rd 3, f3 0, rs1 1, rs2 2, f7 0 → out_word 0x002081B3, err 0, one cycle after accept.
- I fmt, op 0x13, rd 1, rs1 0, imm 0xFFFFFFFF → 0xFFF00093. Then S fmt, op 0x23, f3 2, rs1 1, rs2 2, imm 8 → 0x0020A423.
- B fmt, op 0x63, imm −4 → 0xFE000EE3. Then J fmt, op 0x6F, rd 1, imm 0x800 → 0x001000EF.
- out_ready=0, three back-to-back inputs → two accepted, in_ready low from the second accept. Release out_ready → words emerge in order, then the third is accepted.
- fmt 7 → 0x00000013 with err 1. I fmt imm 2048 → err 1 only with ENC_RANGE_CHECK_EN; word 0x80000093 (op 0x13, rd 1) either way.
- rst for one cycle with two words queued → out_valid 0 and enc_count 0 next cycle; a subsequent input encodes normally.
